// File: rtl/debug_mem_bridge.sv
// debug_mem_bridge: host-side master for the core's debug (second) RAM ports.
// Takes word-granular read/write burst commands, walks the selected RAM one
// word per beat, and returns read data or a single write acknowledge.
module debug_mem_bridge #(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_sel,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_be,
  input  logic [7:0]        cmd_len,
  // write data channel
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [31:0]       wd_data,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_last,
  output logic              busy,
  // data RAM debug port
  output logic [ADDR_W-1:0] dram_a2,
  output logic [31:0]       dram_wd2,
  output logic [3:0]        dram_we2,
  input  logic [31:0]       dram_rd2,
  // instruction RAM debug port
  output logic [ADDR_W-1:0] iram_a2,
  output logic [31:0]       iram_wd2,
  output logic [3:0]        iram_we2,
  input  logic [31:0]       iram_rd2
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_RESP  = 3'd2,
    WR_DATA  = 3'd3,
    WR_PULSE = 3'd4,
    WR_ACK   = 3'd5
  } state_t;

  // Wait counter preload; RD_LATENCY is limited to 1..4 so 3 bits suffice.
  localparam logic [2:0] RdLatInit = 3'(RD_LATENCY);

  state_t            state;
  logic [ADDR_W-1:0] addrQ;
  logic              selQ;
  logic [3:0]        beQ;
  logic [7:0]        lenQ;
  logic [7:0]        beatQ;
  logic [2:0]        waitCnt;

  logic [ADDR_W-1:0] cmdAddrAligned;
  logic [ADDR_W-1:0] addrNext;
  logic [31:0]       rdSel;
  logic              lastBeat;

  // Next word address; wraps modulo 2^ADDR_W by plain unsigned overflow.
  function automatic logic [ADDR_W-1:0] nextWord(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(4);
  endfunction

  // Byte-address low bits are ignored: commands are word-granular.
  function automatic logic [ADDR_W-1:0] alignWord(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

  assign cmdAddrAligned = alignWord(cmd_addr);
  assign addrNext       = nextWord(addrQ);
  assign rdSel          = selQ ? iram_rd2 : dram_rd2;
  assign lastBeat       = (beatQ == lenQ);

  // Handshake readiness and busy decode straight from the state register.
  always_comb begin
    cmd_ready = (state == IDLE);
    wd_ready  = (state == WR_DATA);
    busy      = (state != IDLE);
  end

  // Main FSM with registered RAM-port and response outputs; reset aborts
  // any in-flight command, including a write pulse, without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addrQ     <= '0;
      selQ      <= 1'b0;
      beQ       <= 4'd0;
      lenQ      <= 8'd0;
      beatQ     <= 8'd0;
      waitCnt   <= 3'd0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= 32'd0;
      dram_a2   <= '0;
      dram_wd2  <= 32'd0;
      dram_we2  <= 4'd0;
      iram_a2   <= '0;
      iram_wd2  <= 32'd0;
      iram_we2  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            selQ     <= cmd_sel;
            beQ      <= cmd_be;
            lenQ     <= cmd_len;
            beatQ    <= 8'd0;
            addrQ    <= cmdAddrAligned;
            // Only the selected RAM sees the address; the other port idles at 0.
            dram_a2  <= cmd_sel ? '0 : cmdAddrAligned;
            iram_a2  <= cmd_sel ? cmdAddrAligned : '0;
            dram_wd2 <= 32'd0;
            iram_wd2 <= 32'd0;
            dram_we2 <= 4'd0;
            iram_we2 <= 4'd0;
            if (cmd_write) begin
              state <= WR_DATA;
            end else begin
              waitCnt <= RdLatInit;
              state   <= RD_WAIT;
            end
          end
        end

        RD_WAIT: begin
          // RD_LATENCY countdown edges, then one capture edge.
          if (waitCnt == 3'd0) begin
            rsp_data  <= rdSel;
            rsp_valid <= 1'b1;
            rsp_last  <= lastBeat;
            state     <= RD_RESP;
          end else begin
            waitCnt <= waitCnt - 3'd1;
          end
        end

        RD_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            if (lastBeat) begin
              state <= IDLE;
            end else begin
              addrQ   <= addrNext;
              dram_a2 <= selQ ? '0 : addrNext;
              iram_a2 <= selQ ? addrNext : '0;
              beatQ   <= beatQ + 8'd1;
              waitCnt <= RdLatInit;
              state   <= RD_WAIT;
            end
          end
        end

        WR_DATA: begin
          if (wd_valid) begin
            if (selQ) begin
              iram_wd2 <= wd_data;
              iram_we2 <= beQ;
            end else begin
              dram_wd2 <= wd_data;
              dram_we2 <= beQ;
            end
            state <= WR_PULSE;
          end
        end

        WR_PULSE: begin
          // Write enables are a single-cycle pulse with the address held stable.
          dram_we2 <= 4'd0;
          iram_we2 <= 4'd0;
          if (!lastBeat) begin
            addrQ   <= addrNext;
            dram_a2 <= selQ ? '0 : addrNext;
            iram_a2 <= selQ ? addrNext : '0;
            beatQ   <= beatQ + 8'd1;
            state   <= WR_DATA;
          end else begin
            rsp_valid <= 1'b1;
            rsp_last  <= 1'b1;
            rsp_data  <= 32'd0;
            state     <= WR_ACK;
          end
        end

        WR_ACK: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
